l1_l2_arbiter: RTL and testbench
================================

# l1_l2_arbiter

Arbitrates the L1 instruction cache and L1 data cache onto the single L2 port, directly downstream of the two `l1_cache_control` instances. It accepts whole-cacheline read requests from the I-side and read/write-back requests from the D-side. It grants one requester at a time, with round-robin on conflict, and latches that requester's address and write data for the whole transaction. It then routes the L2 response and read data back to the owner only.

## Interface
Parameters: none. Widths come from `lc3b_types`: `lc3b_word` is 16 bits, `lc3b_cacheline` is 128 bits.

- `clk`  in  1  single clock; everything is sampled on its rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `i_l2_read`  in  1  I-cache line-fill request; held until `i_l2_resp`
- `i_l2_address`  in  16  I-cache line address
- `i_l2_resp`  out  1  one-cycle completion pulse to the I-cache
- `i_l2_rdata`  out  128  fill data to the I-cache
- `d_l2_read`  in  1  D-cache fill request; held until `d_l2_resp`
- `d_l2_write`  in  1  D-cache write-back request; held until `d_l2_resp`
- `d_l2_address`  in  16  D-cache line address
- `d_l2_wdata`  in  128  D-cache write-back line
- `d_l2_resp`  out  1  one-cycle completion pulse to the D-cache
- `d_l2_rdata`  out  128  fill data to the D-cache
- `l2_read`  out  1  read request to L2
- `l2_write`  out  1  write request to L2
- `l2_address`  out  16  latched address
- `l2_wdata`  out  128  latched write data
- `l2_resp`  in  1  L2 completion pulse
- `l2_rdata`  in  128  L2 read data, valid while `l2_resp` is high

## Operation
- States:
  - `IDLE`: no transaction outstanding.
  - `SERVE_I`: the I-side owns the L2 port.
  - `SERVE_D`: the D-side owns the L2 port.
- Request validity:
  - `i_req = i_l2_read`.
  - `d_req = d_l2_read | d_l2_write`.
  - If `d_l2_read` and `d_l2_write` are both high, the request is a write.
- Grant from `IDLE`:
  - Only one request valid: grant it.
  - Both valid: grant the side that is not `last_grant`.
  - Neither valid: stay in `IDLE`.
- On the grant edge:
  - Capture the owner's address into `addr_q`.
  - Capture `d_l2_wdata` into `wdata_q` for a D write. For a read, `wdata_q` keeps its value.
  - Capture `op_q`: 1 = write, 0 = read.
  - Update `last_grant` to the granted side.
- While in `SERVE_x`:
  - `l2_read = ~op_q` and `l2_write = op_q`. These are decoded from state, not registered again.
  - `l2_address = addr_q` and `l2_wdata = wdata_q`.
  - Input changes on either side are ignored until completion.
- Completion:
  - When `l2_resp` is high in `SERVE_x`, assert `x_l2_resp` in that same cycle (combinational).
  - Next state is `IDLE`.
- Read data routing:
  - `i_l2_rdata` and `d_l2_rdata` both connect directly to `l2_rdata`.
  - Only the resp pulse is steered to the owner.
- `l2_resp` in `IDLE` is ignored: no resp is generated on either side.
- The non-owner's resp is always 0.

## Timing
- Reset (asynchronous, immediate):
  - `state = IDLE`, `addr_q = 0`, `wdata_q = 0`, `op_q = 0`.
  - `last_grant = I`, so the D-side wins the first conflict.
  - Outputs: `l2_read = l2_write = 0`, `i_l2_resp = d_l2_resp = 0`, `l2_address = 0`, `l2_wdata = 0`.
- Request latency: a request sampled in `IDLE` at edge N drives `l2_read` or `l2_write` from cycle N+1.
- Completion latency:
  - `l2_resp` high in cycle M gives the owner's resp in cycle M.
  - The downstream request drops in cycle M+1.
  - The port is back in `IDLE` at M+1, so the next request issues at the earliest in cycle M+2.
- Back-to-back requests: if the D-side follows a write-back immediately with a fill, the fill competes in `IDLE` at M+1 like any other request.
- No combinational path from `l2_resp` to `l2_read` or `l2_write`.
- Reset asserted mid-transaction:
  - The downstream request drops immediately.
  - An `l2_resp` for the abandoned transaction is dropped.
  - The L2 side must also be reset.

## Structure
- The arbiter state enum and the grant-side type (`arb_side_t`: I / D) go in `lc3b_types`, next to `lc3b_word` and `lc3b_cacheline`.
- There is no mandatory sub-module.
- The 128-bit capture is one register with a load enable. It may be built as a generic `cacheline_reg` (async active-low clear, load enable) if the team wants it reused in the L2.

## Test plan
- **I-side fill, idle D-side.** Drive `i_l2_read = 1`, `i_l2_address = 0x1230`; L2 responds after 3 cycles with `rdata = 0xA5…A5`.
  - `l2_read` goes high on the next cycle with `l2_address = 0x1230`.
  - `i_l2_resp` pulses for exactly one cycle with `i_l2_rdata = 0xA5…A5`.
  - `d_l2_resp` stays 0 throughout.
- **D-side write-back, then fill.** Drive `d_l2_write = 1`, `d_l2_address = 0x4000`, `d_l2_wdata = 0xDEAD…BEEF`.
  - `l2_write` is asserted with the latched data; `d_l2_resp` pulses when L2 responds.
  - The D-side then raises `d_l2_read` for address `0x4010`.
  - `l2_read` issues in the cycle after the arbiter returns to `IDLE`.
- **Simultaneous requests after reset.** Raise `i_l2_read` and `d_l2_read` in the same cycle.
  - The D-side is served first.
  - The I-side is served immediately after; `last_grant` alternates.
- **Input instability.** During `SERVE_I`, change `i_l2_address` and toggle `d_l2_write`.
  - `l2_address` holds its latched value.
  - No grant switches until `l2_resp`.
- **Reset mid-transaction.** Pull `reset_n` low during `SERVE_D`.
  - `l2_write` drops with no clock edge.
  - After release, a stray `l2_resp` produces no resp pulse on either side.

Source files
------------

// File: rtl/lc3b_types.sv
// Shared LC-3b memory-hierarchy types.
// Holds the word and cacheline widths plus the L1/L2 arbiter state and grant-side enums.
package lc3b_types;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_cacheline;

  // Ownership of the single L2 port.
  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StServeI = 2'd1,
    StServeD = 2'd2
  } arb_state_t;

  // Requester side used for round-robin bookkeeping.
  typedef enum logic {
    SideI = 1'b0,
    SideD = 1'b1
  } arb_side_t;

endpackage

// File: rtl/cacheline_reg.sv
// Generic load-enabled register with asynchronous active-low clear.
// Ports:
//   clk_i  - clock
//   rst_ni - asynchronous active-low clear
//   load_i - capture d_i on the next rising edge
//   d_i    - data in
//   q_o    - registered data out
module cacheline_reg #(
  parameter int unsigned Width = 128
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] data_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q <= '0;
    end else if (load_i) begin
      data_q <= d_i;
    end
  end

  assign q_o = data_q;

endmodule

// File: rtl/l1_l2_arbiter.sv
// L1 I-cache / D-cache to L2 port arbiter.
// Grants one requester at a time (round-robin on conflict), latches the owner's address,
// operation and write data for the whole transaction, and steers the L2 completion pulse
// back to the owner only. Read data is broadcast to both sides.
// Ports:
//   clk, reset_n                         - clock, asynchronous active-low reset
//   i_l2_read, i_l2_address              - I-cache fill request
//   i_l2_resp, i_l2_rdata                - I-cache completion pulse and fill data
//   d_l2_read, d_l2_write, d_l2_address,
//   d_l2_wdata                           - D-cache fill / write-back request
//   d_l2_resp, d_l2_rdata                - D-cache completion pulse and fill data
//   l2_read, l2_write, l2_address,
//   l2_wdata                             - downstream request to L2
//   l2_resp, l2_rdata                    - L2 completion pulse and read data
module l1_l2_arbiter
  import lc3b_types::*;
(
  input  logic          clk,
  input  logic          reset_n,

  input  logic          i_l2_read,
  input  lc3b_word      i_l2_address,
  output logic          i_l2_resp,
  output lc3b_cacheline i_l2_rdata,

  input  logic          d_l2_read,
  input  logic          d_l2_write,
  input  lc3b_word      d_l2_address,
  input  lc3b_cacheline d_l2_wdata,
  output logic          d_l2_resp,
  output lc3b_cacheline d_l2_rdata,

  output logic          l2_read,
  output logic          l2_write,
  output lc3b_word      l2_address,
  output lc3b_cacheline l2_wdata,
  input  logic          l2_resp,
  input  lc3b_cacheline l2_rdata
);

  arb_state_t    state_q;
  arb_side_t     last_grant_q;
  lc3b_word      addr_q;
  logic          op_q;          // 1 = write, 0 = read
  lc3b_cacheline wdata_q;

  logic i_req;
  logic d_req;
  logic grant_i;
  logic grant_d;
  logic load_wdata;
  logic serving;

  assign i_req = i_l2_read;
  assign d_req = d_l2_read | d_l2_write;

  // Grant is only evaluated in idle; on conflict the side not granted last time wins.
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (state_q == StIdle) begin
      if (i_req && d_req) begin
        if (last_grant_q == SideI) begin
          grant_d = 1'b1;
        end else begin
          grant_i = 1'b1;
        end
      end else begin
        grant_i = i_req;
        grant_d = d_req;
      end
    end
  end

  // Write wins when the D-side raises read and write together.
  assign load_wdata = grant_d & d_l2_write;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      op_q         <= 1'b0;
      last_grant_q <= SideI;
    end else begin
      case (state_q)
        StIdle: begin
          if (grant_i) begin
            state_q      <= StServeI;
            addr_q       <= i_l2_address;
            op_q         <= 1'b0;
            last_grant_q <= SideI;
          end else if (grant_d) begin
            state_q      <= StServeD;
            addr_q       <= d_l2_address;
            op_q         <= d_l2_write;
            last_grant_q <= SideD;
          end
        end
        StServeI, StServeD: begin
          if (l2_resp) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  cacheline_reg #(
    .Width($bits(lc3b_cacheline))
  ) u_wdata_reg (
    .clk_i  (clk),
    .rst_ni (reset_n),
    .load_i (load_wdata),
    .d_i    (d_l2_wdata),
    .q_o    (wdata_q)
  );

  assign serving = (state_q == StServeI) || (state_q == StServeD);

  // Request strobes come from state only, so l2_resp never feeds back into them.
  assign l2_read    = serving & ~op_q;
  assign l2_write   = serving & op_q;
  assign l2_address = addr_q;
  assign l2_wdata   = wdata_q;

  assign i_l2_resp  = (state_q == StServeI) & l2_resp;
  assign d_l2_resp  = (state_q == StServeD) & l2_resp;

  assign i_l2_rdata = l2_rdata;
  assign d_l2_rdata = l2_rdata;

endmodule

// File: tb/tb_l1_l2_arbiter.sv
module tb_l1_l2_arbiter;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         i_l2_read;
  logic [15:0]  i_l2_address;
  logic         i_l2_resp;
  logic [127:0] i_l2_rdata;
  logic         d_l2_read;
  logic         d_l2_write;
  logic [15:0]  d_l2_address;
  logic [127:0] d_l2_wdata;
  logic         d_l2_resp;
  logic [127:0] d_l2_rdata;
  logic         l2_read;
  logic         l2_write;
  logic [15:0]  l2_address;
  logic [127:0] l2_wdata;
  logic         l2_resp;
  logic [127:0] l2_rdata;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  l1_l2_arbiter dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_l2_read    (i_l2_read),
    .i_l2_address (i_l2_address),
    .i_l2_resp    (i_l2_resp),
    .i_l2_rdata   (i_l2_rdata),
    .d_l2_read    (d_l2_read),
    .d_l2_write   (d_l2_write),
    .d_l2_address (d_l2_address),
    .d_l2_wdata   (d_l2_wdata),
    .d_l2_resp    (d_l2_resp),
    .d_l2_rdata   (d_l2_rdata),
    .l2_read      (l2_read),
    .l2_write     (l2_write),
    .l2_address   (l2_address),
    .l2_wdata     (l2_wdata),
    .l2_resp      (l2_resp),
    .l2_rdata     (l2_rdata)
  );

  task automatic clear_inputs();
    i_l2_read = 0; i_l2_address = '0;
    d_l2_read = 0; d_l2_write = 0; d_l2_address = '0; d_l2_wdata = '0;
    l2_resp = 0; l2_rdata = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 0;
    clear_inputs();
    repeat (2) @(negedge clk);
    reset_n = 1;
  endtask

  task automatic test_reset();
    reset_n = 0;
    clear_inputs();
    l2_resp = 1;
    #3;
    checks++;
    if ({l2_read, l2_write, i_l2_resp, d_l2_resp} !== 4'b0) begin
      failures++;
      $display("FAIL reset_ctrl: got rd/wr/iresp/dresp=%b want 0000",
               {l2_read, l2_write, i_l2_resp, d_l2_resp});
    end
    checks++;
    if (l2_address !== 16'h0 || l2_wdata !== 128'h0) begin
      failures++;
      $display("FAIL reset_data: got addr=%h wdata=%h want 0", l2_address, l2_wdata);
    end
    l2_resp = 0;
    repeat (2) @(negedge clk);
    reset_n = 1;
  endtask

  task automatic test_i_fill();
    logic [127:0] a5;
    a5 = {16{8'hA5}};
    do_reset();
    i_l2_read = 1; i_l2_address = 16'h1230;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (l2_read !== 1 || l2_write !== 0 || l2_address !== 16'h1230 ||
          i_l2_resp !== 0 || d_l2_resp !== 0) begin
        failures++;
        $display("FAIL ifill_wait%0d: got rd=%b wr=%b addr=%h iresp=%b dresp=%b want 1 0 1230 0 0",
                 k, l2_read, l2_write, l2_address, i_l2_resp, d_l2_resp);
      end
    end
    l2_resp = 1; l2_rdata = a5;
    #1;
    checks++;
    if (i_l2_resp !== 1 || d_l2_resp !== 0 || i_l2_rdata !== a5) begin
      failures++;
      $display("FAIL ifill_resp: got iresp=%b dresp=%b rdata=%h want 1 0 %h",
               i_l2_resp, d_l2_resp, i_l2_rdata, a5);
    end
    @(negedge clk);
    l2_resp = 0; i_l2_read = 0;
    #1;
    checks++;
    if (i_l2_resp !== 0 || d_l2_resp !== 0 || l2_read !== 0) begin
      failures++;
      $display("FAIL ifill_after: got iresp=%b dresp=%b rd=%b want 0 0 0",
               i_l2_resp, d_l2_resp, l2_read);
    end
  endtask

  task automatic test_d_wb_fill();
    logic [127:0] db;
    db = {4{32'hDEADBEEF}};
    do_reset();
    d_l2_write = 1; d_l2_address = 16'h4000; d_l2_wdata = db;
    @(negedge clk);
    checks++;
    if (l2_write !== 1 || l2_read !== 0 || l2_address !== 16'h4000 || l2_wdata !== db) begin
      failures++;
      $display("FAIL dwb_issue: got wr=%b rd=%b addr=%h wdata=%h want 1 0 4000 %h",
               l2_write, l2_read, l2_address, l2_wdata, db);
    end
    l2_resp = 1;
    #1;
    checks++;
    if (d_l2_resp !== 1 || i_l2_resp !== 0) begin
      failures++;
      $display("FAIL dwb_resp: got dresp=%b iresp=%b want 1 0", d_l2_resp, i_l2_resp);
    end
    @(negedge clk);
    l2_resp = 0; d_l2_write = 0; d_l2_read = 1; d_l2_address = 16'h4010; d_l2_wdata = '1;
    checks++;
    if (l2_write !== 0 || l2_read !== 0) begin
      failures++;
      $display("FAIL dwb_idle: got wr=%b rd=%b want 0 0", l2_write, l2_read);
    end
    @(negedge clk);
    checks++;
    if (l2_read !== 1 || l2_write !== 0 || l2_address !== 16'h4010 || l2_wdata !== db) begin
      failures++;
      $display("FAIL dfill_issue: got rd=%b wr=%b addr=%h wdata=%h want 1 0 4010 %h",
               l2_read, l2_write, l2_address, l2_wdata, db);
    end
    l2_resp = 1;
    #1;
    checks++;
    if (d_l2_resp !== 1) begin
      failures++;
      $display("FAIL dfill_resp: got dresp=%b want 1", d_l2_resp);
    end
    @(negedge clk);
    l2_resp = 0; d_l2_read = 0;
  endtask

  task automatic test_simultaneous();
    do_reset();
    for (int r = 0; r < 2; r++) begin
      i_l2_read = 1; i_l2_address = 16'h1111;
      d_l2_read = 1; d_l2_address = 16'h2222;
      @(negedge clk);
      checks++;
      if (l2_read !== 1 || l2_address !== 16'h2222) begin
        failures++;
        $display("FAIL simul_d_first%0d: got rd=%b addr=%h want 1 2222", r, l2_read, l2_address);
      end
      l2_resp = 1;
      #1;
      checks++;
      if (d_l2_resp !== 1 || i_l2_resp !== 0) begin
        failures++;
        $display("FAIL simul_d_resp%0d: got dresp=%b iresp=%b want 1 0", r, d_l2_resp, i_l2_resp);
      end
      @(negedge clk);
      l2_resp = 0; d_l2_read = 0;
      @(negedge clk);
      checks++;
      if (l2_read !== 1 || l2_address !== 16'h1111) begin
        failures++;
        $display("FAIL simul_i_next%0d: got rd=%b addr=%h want 1 1111", r, l2_read, l2_address);
      end
      l2_resp = 1;
      #1;
      checks++;
      if (i_l2_resp !== 1 || d_l2_resp !== 0) begin
        failures++;
        $display("FAIL simul_i_resp%0d: got iresp=%b dresp=%b want 1 0", r, i_l2_resp, d_l2_resp);
      end
      @(negedge clk);
      l2_resp = 0; i_l2_read = 0;
    end
  endtask

  task automatic test_instability();
    do_reset();
    i_l2_read = 1; i_l2_address = 16'h0A00;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      i_l2_address = 16'($urandom);
      d_l2_address = 16'($urandom);
      d_l2_write = ~d_l2_write;
      @(negedge clk);
      checks++;
      if (l2_address !== 16'h0A00 || l2_read !== 1 || l2_write !== 0 || d_l2_resp !== 0) begin
        failures++;
        $display("FAIL instab_hold%0d: got addr=%h rd=%b wr=%b dresp=%b want 0a00 1 0 0",
                 k, l2_address, l2_read, l2_write, d_l2_resp);
      end
    end
    d_l2_write = 0;
    l2_resp = 1;
    #1;
    checks++;
    if (i_l2_resp !== 1 || d_l2_resp !== 0) begin
      failures++;
      $display("FAIL instab_resp: got iresp=%b dresp=%b want 1 0", i_l2_resp, d_l2_resp);
    end
    @(negedge clk);
    l2_resp = 0; i_l2_read = 0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    d_l2_write = 1; d_l2_address = 16'h5550; d_l2_wdata = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    checks++;
    if (l2_write !== 1) begin
      failures++;
      $display("FAIL rstmid_pre: got wr=%b want 1", l2_write);
    end
    #2;
    reset_n = 0;
    #1;
    checks++;
    if (l2_write !== 0 || l2_read !== 0 || l2_address !== 16'h0 || l2_wdata !== 128'h0) begin
      failures++;
      $display("FAIL rstmid_drop: got wr=%b rd=%b addr=%h wdata=%h want 0 0 0 0",
               l2_write, l2_read, l2_address, l2_wdata);
    end
    clear_inputs();
    @(negedge clk);
    reset_n = 1;
    @(negedge clk);
    l2_resp = 1;
    #1;
    checks++;
    if (i_l2_resp !== 0 || d_l2_resp !== 0 || l2_read !== 0 || l2_write !== 0) begin
      failures++;
      $display("FAIL rstmid_stray: got iresp=%b dresp=%b rd=%b wr=%b want 0 0 0 0",
               i_l2_resp, d_l2_resp, l2_read, l2_write);
    end
    @(negedge clk);
    l2_resp = 0;
  endtask

  // Transaction-level model: pending requests per side, round-robin memory, latched write data.
  task automatic test_random();
    bit pend_i, pend_d, last_d, win_d, exp_wr;
    logic [15:0]  a_i, a_d, exp_addr;
    logic [127:0] wd, exp_wdata, rd;
    logic [1:0]   dk;
    int lat;
    pend_i = 0; pend_d = 0; last_d = 0; exp_wdata = '0;
    a_i = '0; a_d = '0; wd = '0; dk = 2'd1;
    do_reset();
    for (int t = 0; t < 60; t++) begin
      if (!pend_i && $urandom_range(1) == 1) begin
        pend_i = 1; a_i = 16'($urandom);
      end
      if (!pend_d && ($urandom_range(1) == 1 || !pend_i)) begin
        pend_d = 1; a_d = 16'($urandom); wd = {$urandom, $urandom, $urandom, $urandom};
        dk = 2'($urandom_range(1, 3));
      end
      i_l2_read = pend_i; i_l2_address = a_i;
      d_l2_read = pend_d & dk[0]; d_l2_write = pend_d & dk[1];
      d_l2_address = a_d; d_l2_wdata = wd;
      win_d = (pend_i && pend_d) ? !last_d : pend_d;
      last_d = win_d;
      exp_addr = win_d ? a_d : a_i;
      exp_wr = win_d && dk[1];
      if (exp_wr) exp_wdata = wd;
      checks++;
      if (l2_read !== 0 || l2_write !== 0) begin
        failures++;
        $display("FAIL rnd_idle%0d: got rd=%b wr=%b want 0 0", t, l2_read, l2_write);
      end
      @(negedge clk);
      lat = $urandom_range(0, 3);
      for (int k = 0; k <= lat; k++) begin
        checks++;
        if (l2_read !== !exp_wr || l2_write !== exp_wr || l2_address !== exp_addr ||
            l2_wdata !== exp_wdata || i_l2_resp !== 0 || d_l2_resp !== 0) begin
          failures++;
          $display("FAIL rnd_serve%0d.%0d: got rd=%b wr=%b addr=%h wdata=%h resp=%b%b want %b %b %h %h 00",
                   t, k, l2_read, l2_write, l2_address, l2_wdata, i_l2_resp, d_l2_resp,
                   !exp_wr, exp_wr, exp_addr, exp_wdata);
        end
        if (k < lat) begin
          i_l2_address = 16'($urandom); d_l2_address = 16'($urandom);
          d_l2_wdata = {$urandom, $urandom, $urandom, $urandom};
          if (win_d) i_l2_read = 1'($urandom);
          else begin d_l2_read = 1'($urandom); d_l2_write = 1'($urandom); end
          @(negedge clk);
        end
      end
      i_l2_read = pend_i; i_l2_address = a_i;
      d_l2_read = pend_d & dk[0]; d_l2_write = pend_d & dk[1];
      d_l2_address = a_d; d_l2_wdata = wd;
      rd = {$urandom, $urandom, $urandom, $urandom};
      l2_resp = 1; l2_rdata = rd;
      #1;
      checks++;
      if (i_l2_resp !== !win_d || d_l2_resp !== win_d ||
          i_l2_rdata !== rd || d_l2_rdata !== rd) begin
        failures++;
        $display("FAIL rnd_resp%0d: got iresp=%b dresp=%b irdata=%h drdata=%h want %b %b %h",
                 t, i_l2_resp, d_l2_resp, i_l2_rdata, d_l2_rdata, !win_d, win_d, rd);
      end
      @(negedge clk);
      l2_resp = 0;
      if (win_d) pend_d = 0; else pend_i = 0;
      i_l2_read = pend_i; d_l2_read = pend_d & dk[0]; d_l2_write = pend_d & dk[1];
    end
    clear_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running want done");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_i_fill();
    test_d_wb_fill();
    test_simultaneous();
    test_instability();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
